// File: rtl/main_pkg.sv
// Shared constants, phase encoding and helpers for the matrix-multiply block.
package main_pkg;

  localparam int unsigned MAX_DIM   = 8;
  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned MAX_CORES = 4;
  localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);
  localparam int unsigned DIM_W     = $clog2(MAX_DIM + 1);

  // A starts right after the M/K/N header; C lives in the top 64 words.
  localparam logic [ADDR_W-1:0] A_BASE   = 8'd3;
  localparam logic [ADDR_W-1:0] RES_BASE = 8'd192;

  typedef enum logic [1:0] {
    StLoad    = 2'b00,
    StCompute = 2'b01,
    StOutput  = 2'b10,
    StDone    = 2'b11
  } state_e;

  // Number of active cores from the enable mask; anything but a contiguous
  // run of ones starting at bit 0 falls back to a single core.
  function automatic logic [2:0] cores_from_mask(input logic [3:0] mask);
    logic [2:0] p;
    case (mask)
      4'b0011: p = 3'd2;
      4'b0111: p = 3'd3;
      4'b1111: p = 3'd4;
      default: p = 3'd1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/main_mac_core.sv
// One multiply-accumulate lane: 16-bit wrap-around accumulator with clear/enable.
module mac_core
  import main_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] acc_q, acc_d;

  // Clear wins over enable so the write-back cycle restarts the sum.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + a_i * b_i;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/main.sv
// Streamed matrix multiplier: loads M/K/N, A and B, computes C = A x B on up to
// four lockstep MAC cores (row-interleaved), then streams C out row-major.
module main
  import main_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] com_data_in,
  input  logic              data_write_start,
  input  logic              data_write_done,
  input  logic [3:0]        n_cores,
  output logic [1:0]        state,
  output logic [DATA_W-1:0] com_data_out,
  output logic              output_write_start,
  output logic              output_write_done
);

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DIM_W-1:0]  dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;
  logic [2:0]        p_q, p_d;
  logic [DIM_W-1:0]  kk_q, kk_d, col_q, col_d;
  logic [DIM_W:0]    row_base_q, row_base_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic [DATA_W-1:0] last_q, last_d;

  logic [ADDR_W-1:0] mk, kn, mn;
  logic [ADDR_W:0]   load_limit;
  logic              capture, compute_last, out_last;
  logic [DATA_W-1:0] res_word;

  logic [MAX_CORES-1:0] core_act, core_en, core_clr, core_wr;
  logic [ADDR_W-1:0]    core_a_addr  [MAX_CORES];
  logic [ADDR_W-1:0]    core_b_addr  [MAX_CORES];
  logic [ADDR_W-1:0]    core_wb_addr [MAX_CORES];
  logic [DATA_W-1:0]    core_acc     [MAX_CORES];

  // Derived sizes, load gating and phase-end conditions.
  always_comb begin
    mk         = ADDR_W'(dim_m_q) * ADDR_W'(dim_k_q);
    kn         = ADDR_W'(dim_k_q) * ADDR_W'(dim_n_q);
    mn         = ADDR_W'(dim_m_q) * ADDR_W'(dim_n_q);
    load_limit = (ADDR_W + 1)'(A_BASE) + (ADDR_W + 1)'(mk) + (ADDR_W + 1)'(kn);
    capture    = (state_q == StLoad) && (data_write_start || data_write_done) &&
                 ({1'b0, wr_addr_q} < load_limit) && (wr_addr_q < RES_BASE);
    compute_last = (kk_q == dim_k_q) && (col_q == dim_n_q - DIM_W'(1)) &&
                   ((row_base_q + (DIM_W + 1)'(p_q)) >= (DIM_W + 1)'(dim_m_m_fix()));
    out_last   = (out_idx_q == mn - ADDR_W'(1));
    res_word   = mem_q[RES_BASE + out_idx_q];
  end

  function automatic logic [DIM_W-1:0] dim_m_m_fix();
    return dim_m_q;
  endfunction

  // Per-core row selection and operand/write-back addressing.
  always_comb begin
    logic [DIM_W:0] row;
    row      = '0;
    core_act = '0;
    core_en  = '0;
    core_clr = '1;
    core_wr  = '0;
    for (int c = 0; c < int'(MAX_CORES); c++) begin
      row             = row_base_q + (DIM_W + 1)'(c);
      core_act[c]     = (state_q == StCompute) && (3'(c) < p_q) &&
                        (row < (DIM_W + 1)'(dim_m_q));
      core_en[c]      = core_act[c] && (kk_q != dim_k_q);
      core_clr[c]     = !core_act[c] || (kk_q == dim_k_q);
      core_wr[c]      = core_act[c] && (kk_q == dim_k_q);
      core_a_addr[c]  = A_BASE + ADDR_W'(row) * ADDR_W'(dim_k_q) + ADDR_W'(kk_q);
      core_b_addr[c]  = A_BASE + mk + ADDR_W'(kk_q) * ADDR_W'(dim_n_q) + ADDR_W'(col_q);
      core_wb_addr[c] = RES_BASE + ADDR_W'(row) * ADDR_W'(dim_n_q) + ADDR_W'(col_q);
    end
  end

  for (genvar c = 0; c < int'(MAX_CORES); c++) begin : g_core
    mac_core u_mac (
      .clk_i   (clk),
      .rst_i   (reset),
      .clear_i (core_clr[c]),
      .en_i    (core_en[c]),
      .a_i     (mem_q[core_a_addr[c]]),
      .b_i     (mem_q[core_b_addr[c]]),
      .acc_o   (core_acc[c])
    );
  end

  // Phase register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  // Phase sequencing; DONE only leaves through reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:    if (data_write_done) state_d = StCompute;
      StCompute: if (compute_last) state_d = StOutput;
      StOutput:  if (out_last) state_d = StDone;
      StDone:    state_d = StDone;
      default:   state_d = StLoad;
    endcase
  end

  // Phase outputs; com_data_out keeps the last presented word outside OUTPUT.
  always_comb begin
    state              = state_q;
    output_write_start = (state_q == StOutput);
    output_write_done  = (state_q == StOutput) && out_last;
    com_data_out       = (state_q == StOutput) ? res_word : last_q;
  end

  // Load address, dimension capture, compute counters and output index.
  always_comb begin
    wr_addr_d  = wr_addr_q;
    dim_m_d    = dim_m_q;
    dim_k_d    = dim_k_q;
    dim_n_d    = dim_n_q;
    p_d        = p_q;
    kk_d       = kk_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    out_idx_d  = out_idx_q;
    last_d     = last_q;
    unique case (state_q)
      StLoad: begin
        if (capture) begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          if (wr_addr_q == 8'd0) dim_m_d = com_data_in[DIM_W-1:0];
          if (wr_addr_q == 8'd1) dim_k_d = com_data_in[DIM_W-1:0];
          if (wr_addr_q == 8'd2) dim_n_d = com_data_in[DIM_W-1:0];
        end
        if (data_write_done) p_d = cores_from_mask(n_cores);
      end
      StCompute: begin
        // kk == K is the write-back slot for the element just accumulated.
        if (kk_q != dim_k_q) begin
          kk_d = kk_q + DIM_W'(1);
        end else begin
          kk_d = '0;
          if (col_q != dim_n_q - DIM_W'(1)) begin
            col_d = col_q + DIM_W'(1);
          end else begin
            col_d      = '0;
            row_base_d = row_base_q + (DIM_W + 1)'(p_q);
          end
        end
      end
      StOutput: begin
        out_idx_d = out_idx_q + ADDR_W'(1);
        last_d    = res_word;
      end
      default: ;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr_q  <= '0;
      dim_m_q    <= '0;
      dim_k_q    <= '0;
      dim_n_q    <= '0;
      p_q        <= 3'd1;
      kk_q       <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      out_idx_q  <= '0;
      last_q     <= '0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      dim_m_q    <= dim_m_d;
      dim_k_q    <= dim_k_d;
      dim_n_q    <= dim_n_d;
      p_q        <= p_d;
      kk_q       <= kk_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
      out_idx_q  <= out_idx_d;
      last_q     <= last_d;
    end
  end

  // Data memory (not reset): load captures and per-core result write-back.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q[wr_addr_q] <= com_data_in;
    end
    for (int c = 0; c < int'(MAX_CORES); c++) begin
      if (core_wr[c]) begin
        mem_q[core_wb_addr[c]] <= core_acc[c];
      end
    end
  end

endmodule

// File: tb/tb_main.sv
// Directed bench for main: scoreboard of model results, compared as C streams out.
module tb_main;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] com_data_in;
  logic        data_write_start;
  logic        data_write_done;
  logic [3:0]  n_cores;
  logic [1:0]  state;
  logic [15:0] com_data_out;
  logic        output_write_start;
  logic        output_write_done;

  main dut (
    .clk                (clk),
    .reset              (reset),
    .com_data_in        (com_data_in),
    .data_write_start   (data_write_start),
    .data_write_done    (data_write_done),
    .n_cores            (n_cores),
    .state              (state),
    .com_data_out       (com_data_out),
    .output_write_start (output_write_start),
    .output_write_done  (output_write_done)
  );

  always #5 clk = ~clk;

  int          n_asserts = 0;
  int          n_fail    = 0;
  int          stream_q[$];
  logic [15:0] sb_q[$];
  int          cur_m, cur_k, cur_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference C = A x B (mod 2^16) from the stream, pushed row-major.
  task automatic model_push();
    logic [15:0] s;
    cur_m = stream_q[0];
    cur_k = stream_q[1];
    cur_n = stream_q[2];
    for (int i = 0; i < cur_m; i++) begin
      for (int j = 0; j < cur_n; j++) begin
        s = '0;
        for (int x = 0; x < cur_k; x++) begin
          s = s + 16'(stream_q[3 + i * cur_k + x] * stream_q[3 + cur_m * cur_k + x * cur_n + j]);
        end
        sb_q.push_back(s);
      end
    end
  endtask

  task automatic load_stream(input logic [3:0] mask);
    model_push();
    n_cores = mask;
    for (int i = 0; i < stream_q.size(); i++) begin
      @(negedge clk);
      com_data_in      = 16'(stream_q[i]);
      data_write_start = 1'b1;
      data_write_done  = (i == stream_q.size() - 1);
    end
    @(negedge clk);
    data_write_start = 1'b0;
    data_write_done  = 1'b0;
    com_data_in      = '0;
    chk("enter_compute", 32'(state), 32'd1);
  endtask

  task automatic finish_case(input string tag, input int p);
    int          cyc;
    int          maxc;
    int          guard;
    logic [15:0] exp;
    logic [15:0] last;
    maxc = ((cur_m + p - 1) / p) * cur_n * (cur_k + 1) + 2;
    cyc  = 0;
    while (state == 2'b01 && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_compute_len_ok"}, 32'(cyc <= maxc), 32'd1);
    chk({tag, "_enter_output"}, 32'(state), 32'd2);
    guard = 0;
    last  = '0;
    while (state == 2'b10 && guard < 100) begin
      if (sb_q.size() == 0) begin
        chk({tag, "_extra_word"}, 32'(sb_q.size()), 32'd1);
        break;
      end
      exp = sb_q.pop_front();
      chk({tag, "_data"}, 32'(com_data_out), 32'(exp));
      chk({tag, "_ows"}, 32'(output_write_start), 32'd1);
      chk({tag, "_owd"}, 32'(output_write_done), 32'(sb_q.size() == 0));
      last = exp;
      guard++;
      @(negedge clk);
    end
    chk({tag, "_words_left"}, 32'(sb_q.size()), 32'd0);
    chk({tag, "_done_state"}, 32'(state), 32'd3);
    chk({tag, "_done_ows"}, 32'(output_write_start), 32'd0);
    chk({tag, "_done_owd"}, 32'(output_write_done), 32'd0);
    chk({tag, "_done_hold"}, 32'(com_data_out), 32'(last));
    // Host strobes after the run must not disturb DONE.
    data_write_start = 1'b1;
    data_write_done  = 1'b1;
    com_data_in      = 16'hBEEF;
    repeat (2) @(negedge clk);
    data_write_start = 1'b0;
    data_write_done  = 1'b0;
    com_data_in      = '0;
    chk({tag, "_sticky"}, 32'(state), 32'd3);
    chk({tag, "_sticky_hold"}, 32'(com_data_out), 32'(last));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_dout", 32'(com_data_out), 32'd0);
    chk("rst_ows", 32'(output_write_start), 32'd0);
    chk("rst_owd", 32'(output_write_done), 32'd0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_2x2();
    stream_q = '{2, 2, 2, 1, 2, 3, 4, 5, 6, 7, 8};
  endtask

  initial begin
    reset            = 1'b1;
    com_data_in      = '0;
    data_write_start = 1'b0;
    data_write_done  = 1'b0;
    n_cores          = 4'b0001;
    repeat (2) @(negedge clk);
    chk("init_state", 32'(state), 32'd0);
    chk("init_dout", 32'(com_data_out), 32'd0);
    chk("init_ows", 32'(output_write_start), 32'd0);
    chk("init_owd", 32'(output_write_done), 32'd0);
    reset = 1'b0;

    set_2x2(); load_stream(4'b1111); finish_case("c2x2_p4", 4);
    do_reset(); set_2x2(); load_stream(4'b0001); finish_case("c2x2_p1", 1);
    do_reset(); set_2x2(); load_stream(4'b0011); finish_case("c2x2_p2", 2);
    do_reset(); set_2x2(); load_stream(4'b0111); finish_case("c2x2_p3", 3);
    do_reset(); set_2x2(); load_stream(4'b0000); finish_case("c2x2_m0", 1);

    do_reset();
    stream_q = '{1, 1, 1, 300, 300};
    load_stream(4'b0101);
    finish_case("c1x1_wrap", 1);

    do_reset();
    stream_q = '{3, 3, 3, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    load_stream(4'b0111);
    finish_case("ident3", 3);

    // Trailing word beyond the matrices must be dropped.
    do_reset();
    stream_q = '{2, 2, 2, 1, 2, 3, 4, 5, 6, 7, 8, 999};
    load_stream(4'b0011);
    finish_case("c2x2_extra", 2);

    // Abort during COMPUTE, then a clean reload.
    do_reset();
    set_2x2();
    load_stream(4'b0001);
    repeat (3) @(negedge clk);
    chk("mid_compute_state", 32'(state), 32'd1);
    do_reset();
    set_2x2();
    load_stream(4'b1111);
    finish_case("after_abort", 4);

    do_reset();
    stream_q = '{8, 8, 8};
    for (int i = 0; i < 128; i++) stream_q.push_back(1);
    load_stream(4'b1111);
    finish_case("ones8", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
